// File: rtl/exec_pkg.sv
// exec_pkg: shared definitions for the execute stage.
//   - DEFAULT_WIDTH  : default datapath width
//   - OP_*           : instruction opcodes
//   - FN_*           : R-type function codes
//   - alu_op_t       : ALU operation encoding driven on alu_ctrl
package exec_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned SHAMT_W       = 4;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_JTYPE = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_FOR   = 4'b1000;

    localparam logic [2:0] FN_AND = 3'b000;
    localparam logic [2:0] FN_ADD = 3'b001;
    localparam logic [2:0] FN_SUB = 3'b010;
    localparam logic [2:0] FN_SLL = 3'b011;
    localparam logic [2:0] FN_SRL = 3'b100;
    localparam logic [2:0] FN_SRA = 3'b101;

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluAdd = 3'b001,
        AluSub = 3'b010,
        AluSll = 3'b011,
        AluSrl = 3'b100,
        AluSra = 3'b101
    } alu_op_t;

endpackage

// File: rtl/exec_if.sv
// exec_if: execute-stage signal bundle.
//   master : drives opcode, func, a, b, pc, offset, result_en; observes results
//   slave  : the execute unit; drives alu_ctrl, alu_out, zero, neg, overflow,
//            result_buffer, branch_address
interface exec_if #(
    parameter int unsigned WIDTH = exec_pkg::DEFAULT_WIDTH
) ();

    logic [3:0]       opcode;
    logic [2:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] offset;
    logic             result_en;

    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             neg;
    logic             overflow;
    logic [WIDTH-1:0] result_buffer;
    logic [WIDTH-1:0] branch_address;

    modport master (
        output opcode, func, a, b, pc, offset, result_en,
        input  alu_ctrl, alu_out, zero, neg, overflow, result_buffer, branch_address
    );

    modport slave (
        input  opcode, func, a, b, pc, offset, result_en,
        output alu_ctrl, alu_out, zero, neg, overflow, result_buffer, branch_address
    );

endinterface

// File: rtl/exec_alu_decode.sv
// exec_alu_decode: opcode/func to ALU operation, purely combinational.
//   i_opcode : instruction opcode
//   i_func   : R-type function field
//   o_alu_op : decoded ALU operation
// Optional macro EXEC_SRA_EN: R-type func 101 decodes to AluSra instead of AluAdd.
module exec_alu_decode
    import exec_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic [2:0] i_func,
    output alu_op_t    o_alu_op
);

    always_comb begin
        o_alu_op = AluAdd;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_func)
                    FN_AND:  o_alu_op = AluAnd;
                    FN_ADD:  o_alu_op = AluAdd;
                    FN_SUB:  o_alu_op = AluSub;
                    FN_SLL:  o_alu_op = AluSll;
                    FN_SRL:  o_alu_op = AluSrl;
`ifdef EXEC_SRA_EN
                    FN_SRA:  o_alu_op = AluSra;
`endif
                    // Unused func codes fall back to ADD
                    default: o_alu_op = AluAdd;
                endcase
            end
            OP_ANDI:                    o_alu_op = AluAnd;
            OP_ADDI, OP_LW, OP_SW:      o_alu_op = AluAdd;
            OP_BEQ, OP_BNE, OP_FOR:     o_alu_op = AluSub;
            OP_JTYPE:                   o_alu_op = AluAdd;
            default:                    o_alu_op = AluAdd;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 16-bit multicycle processor.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears result_buffer only)
//   bus   : exec_if.slave
//           in : opcode, func, a, b, pc, offset, result_en
//           out: alu_ctrl, alu_out, zero, neg, overflow (combinational),
//                result_buffer (registered alu_out), branch_address (pc + offset)
// Optional macro EXEC_SRA_EN: enables the arithmetic right shift operation.
module exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    exec_if.slave bus
);

    localparam int unsigned MSB = WIDTH - 1;

    alu_op_t              w_alu_op;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [SHAMT_W-1:0]   w_shamt;
    logic [WIDTH-1:0]     w_alu_out;
    logic                 w_overflow;
    logic [WIDTH-1:0]     r_result_buffer;

    exec_alu_decode u_decode (
        .i_opcode (bus.opcode),
        .i_func   (bus.func),
        .o_alu_op (w_alu_op)
    );

    assign w_a     = bus.a;
    assign w_b     = bus.b;
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;
    assign w_shamt = w_b[SHAMT_W-1:0];

    always_comb begin
        w_alu_out  = '0;
        w_overflow = 1'b0;
        case (w_alu_op)
            AluAnd: w_alu_out = w_a & w_b;
            AluAdd: begin
                w_alu_out  = w_sum;
                // Like-signed operands producing an opposite-signed sum
                w_overflow = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);
            end
            AluSub: begin
                w_alu_out  = w_diff;
                // Unlike-signed operands where the result sign departs from a
                w_overflow = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
            end
            AluSll: w_alu_out = w_a << w_shamt;
            AluSrl: w_alu_out = w_a >> w_shamt;
`ifdef EXEC_SRA_EN
            AluSra: w_alu_out = $unsigned($signed(w_a) >>> w_shamt);
`endif
            default: begin
                w_alu_out  = '0;
                w_overflow = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result_buffer <= '0;
        end else if (bus.result_en) begin
            r_result_buffer <= w_alu_out;
        end
    end

    assign bus.alu_ctrl       = w_alu_op;
    assign bus.alu_out        = w_alu_out;
    assign bus.zero           = (w_alu_out == '0);
    assign bus.neg            = w_alu_out[MSB];
    assign bus.overflow       = w_overflow;
    assign bus.result_buffer  = r_result_buffer;
    assign bus.branch_address = bus.pc + bus.offset;

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: self-checking bench for exec_unit.
// An arithmetic reference model (signed integers, division/multiplication by
// powers of two) predicts every output; a negedge process compares all outputs
// each cycle, and directed steps pin the model with literal expectations.
// Honours EXEC_SRA_EN the same way as the design.
module tb_exec_unit;

    logic clk;
    logic reset;
    logic chk_en;
    int   total;
    int   bad;

    exec_if #(.WIDTH(16)) bus ();

    exec_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [2:0] m_ctrl(input logic [3:0] op, input logic [2:0] fn);
        if (op == 4'd0) begin
            if (fn <= 3'd4) return fn;
`ifdef EXEC_SRA_EN
            if (fn == 3'd5) return 3'd5;
`endif
            return 3'd1;
        end
        if (op == 4'd2) return 3'd0;
        if (op >= 4'd6 && op <= 4'd8) return 3'd2;
        return 3'd1;
    endfunction

    // Returns {overflow, result}
    function automatic logic [16:0] m_eval(input logic [3:0] op, input logic [2:0] fn,
                                           input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, r, d;
        logic [15:0] o;
        logic v;
        sa = (a >= 16'h8000) ? longint'(a) - 65536 : longint'(a);
        sb = (b >= 16'h8000) ? longint'(b) - 65536 : longint'(b);
        d  = 2 ** int'(b[3:0]);
        v  = 1'b0;
        o  = 16'h0;
        case (m_ctrl(op, fn))
            3'd0: o = a & b;
            3'd1: begin
                r = sa + sb;
                o = 16'(r);
                v = (r > 32767) || (r < -32768);
            end
            3'd2: begin
                r = sa - sb;
                o = 16'(r);
                v = (r > 32767) || (r < -32768);
            end
            3'd3: o = 16'(longint'(a) * d);
            3'd4: o = 16'(longint'(a) / d);
            3'd5: begin
                r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
                o = 16'(r);
            end
            default: o = 16'h0;
        endcase
        return {v, o};
    endfunction

    logic [2:0]  exp_ctrl;
    logic [16:0] exp_eval;
    logic [15:0] exp_out;
    logic [15:0] exp_rb;
    logic [15:0] exp_br;

    assign exp_ctrl = m_ctrl(bus.opcode, bus.func);
    assign exp_eval = m_eval(bus.opcode, bus.func, bus.a, bus.b);
    assign exp_out  = exp_eval[15:0];
    assign exp_br   = 16'(32'(bus.pc) + 32'(bus.offset));

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_rb <= 16'h0;
        else if (bus.result_en) exp_rb <= exp_out;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_alu_ctrl", 32'(bus.alu_ctrl), 32'(exp_ctrl));
            chk("m_alu_out", 32'(bus.alu_out), 32'(exp_out));
            chk("m_zero", 32'(bus.zero), 32'(exp_out == 16'h0));
            chk("m_neg", 32'(bus.neg), 32'(exp_out[15]));
            chk("m_overflow", 32'(bus.overflow), 32'(exp_eval[16]));
            chk("m_result_buffer", 32'(bus.result_buffer), 32'(exp_rb));
            chk("m_branch_address", 32'(bus.branch_address), 32'(exp_br));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [2:0] fn,
                          input logic [15:0] a, input logic [15:0] b);
        bus.opcode = op;
        bus.func   = fn;
        bus.a      = a;
        bus.b      = b;
        #1;
    endtask

    function automatic logic [15:0] pick16();
        logic [15:0] edges [5];
        edges[0] = 16'h0000;
        edges[1] = 16'h0001;
        edges[2] = 16'h7FFF;
        edges[3] = 16'h8000;
        edges[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    logic [3:0] sw_op [11];
    logic [2:0] sw_fn [11];
    logic [2:0] sw_ex [11];

    initial begin
        total = 0;
        bad   = 0;
        chk_en = 1'b0;
        reset = 1'b1;
        bus.opcode = 4'd0;
        bus.func = 3'd0;
        bus.a = 16'h0;
        bus.b = 16'h0;
        bus.pc = 16'h0;
        bus.offset = 16'h0;
        bus.result_en = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("reset_rb", 32'(bus.result_buffer), 32'h0);
        chk_en = 1'b1;

        // R-type ADD
        step();
        reset = 1'b1;
        set_in(4'd0, 3'd1, 16'h0005, 16'h0003);
        chk("add_ctrl", 32'(bus.alu_ctrl), 32'd1);
        chk("add_out", 32'(bus.alu_out), 32'h0008);
        chk("add_flags", {29'd0, bus.zero, bus.neg, bus.overflow}, 32'd0);
        step();
        chk("add_rb", 32'(bus.result_buffer), 32'h0008);

        // BEQ equal operands, backward branch
        bus.pc = 16'h0010;
        bus.offset = 16'hFFFC;
        set_in(4'd6, 3'd0, 16'h1234, 16'h1234);
        chk("beq_ctrl", 32'(bus.alu_ctrl), 32'd2);
        chk("beq_out", 32'(bus.alu_out), 32'h0);
        chk("beq_zero", 32'(bus.zero), 32'd1);
        chk("branch_back", 32'(bus.branch_address), 32'h000C);

        step();
        set_in(4'd0, 3'd1, 16'h7FFF, 16'h0001);
        chk("addovf_out", 32'(bus.alu_out), 32'h8000);
        chk("addovf_ovf", 32'(bus.overflow), 32'd1);
        chk("addovf_neg", 32'(bus.neg), 32'd1);
        step();
        set_in(4'd0, 3'd2, 16'h8000, 16'h0001);
        chk("subovf_out", 32'(bus.alu_out), 32'h7FFF);
        chk("subovf_ovf", 32'(bus.overflow), 32'd1);
        step();
        set_in(4'd0, 3'd3, 16'h0001, 16'h0004);
        chk("sll_out", 32'(bus.alu_out), 32'h0010);
        step();
        set_in(4'd0, 3'd4, 16'h8000, 16'h000F);
        chk("srl_out", 32'(bus.alu_out), 32'h0001);
        step();
        set_in(4'd0, 3'd4, 16'hA5A5, 16'h0010);
        chk("srl_zero_shamt", 32'(bus.alu_out), 32'hA5A5);
        step();
        set_in(4'd0, 3'd5, 16'h8000, 16'h0004);
`ifdef EXEC_SRA_EN
        chk("fn5_ctrl", 32'(bus.alu_ctrl), 32'd5);
        chk("fn5_out", 32'(bus.alu_out), 32'hF800);
`else
        chk("fn5_ctrl", 32'(bus.alu_ctrl), 32'd1);
        chk("fn5_out", 32'(bus.alu_out), 32'h8004);
`endif
        chk("fn5_ovf", 32'(bus.overflow), 32'd0);

        // Decode sweep
        sw_op = '{4'd4, 4'd5, 4'd3, 4'd1, 4'd2, 4'd7, 4'd8, 4'd0, 4'd0, 4'd9, 4'd15};
        sw_fn = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd7, 3'd2, 3'd0};
        sw_ex = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1};
        for (int i = 0; i < 11; i++) begin
            step();
            set_in(sw_op[i], sw_fn[i], 16'h00F0, 16'h0F0F);
            chk("decode_sweep", 32'(bus.alu_ctrl), 32'(sw_ex[i]));
        end

        // Asynchronous reset mid-cycle
        step();
        set_in(4'd2, 3'd0, 16'h00FF, 16'hFFFF);
        step();
        chk("load_ff", 32'(bus.result_buffer), 32'h00FF);
        #1 reset = 1'b0;
        #1;
        chk("async_clear", 32'(bus.result_buffer), 32'h0);
        step();
        reset = 1'b1;
        #1;
        chk("reset_held", 32'(bus.result_buffer), 32'h0);
        step();
        chk("reload_ff", 32'(bus.result_buffer), 32'h00FF);

        // Hold with result_en low
        bus.result_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(4'd0, 3'd1, 16'(i * 16'h0111 + 1), 16'h0100);
            step();
            chk("hold_rb", 32'(bus.result_buffer), 32'h00FF);
        end
        bus.result_en = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step();
            reset = 1'b1;
            bus.pc = 16'($urandom);
            bus.offset = pick16();
            bus.result_en = ($urandom_range(0, 7) != 0);
            set_in(4'($urandom_range(0, 15)),
                   ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(3, 5)),
                   pick16(), pick16());
            if ($urandom_range(0, 49) == 0) reset = 1'b0;
        end

        step();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute-stage block of the 16-bit multicycle processor.
- Decodes opcode/func into a 3-bit ALU operation and computes the ALU result and flags combinationally.
- Registers the result into a result buffer that feeds data-memory address and write-back.
- Computes the branch target address, pc + sign-extended offset.

Parameters:
- WIDTH, 16, datapath width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- opcode  in  4  instruction opcode
- func  in  3  R-type function field
- a  in  WIDTH  operand A (latched Rs)
- b  in  WIDTH  operand B (latched Rt or extended immediate, selected upstream)
- pc  in  WIDTH  current PC
- offset  in  WIDTH  sign-extended branch immediate
- result_en  in  1  load enable for result_buffer (tied 1 in the datapath)
- alu_ctrl  out  3  decoded ALU operation
- alu_out  out  WIDTH  combinational ALU result, signed
- zero  out  1  alu_out == 0
- neg  out  1  alu_out[WIDTH-1]
- overflow  out  1  signed overflow flag
- result_buffer  out  WIDTH  registered alu_out
- branch_address  out  WIDTH  pc + offset

Behaviour:
- alu_ctrl encoding: 000 AND, 001 ADD, 010 SUB, 011 SLL, 100 SRL, 101 SRA (only with the optional feature).
- Decode for opcode 0000 (R-type), by func:
  - 000 AND, 001 ADD, 010 SUB, 011 SLL, 100 SRL.
  - 101..111 decode to ADD (101 is SRA when the optional feature is compiled in).
- Decode for other opcodes:
  - 0010 ANDI → AND; 0011 ADDI → ADD; 0100 LW → ADD; 0101 SW → ADD.
  - 0110 BEQ → SUB; 0111 BNE → SUB; 1000 FOR → SUB.
  - 0001 (jump/call/return) and 1001..1111 → ADD.
- alu_ctrl, alu_out, flags and branch_address are purely combinational: zero latency from inputs.
- Shifts:
  - Shift amount is b[3:0]; a is the value shifted.
  - SRL fills with zeros.
  - A shift amount of 0 returns a unchanged.
- ADD/SUB wrap modulo 2^16.
- overflow:
  - ADD: a and b have the same sign and the result sign differs.
  - SUB: a and b have different signs and the result sign differs from a.
  - All other operations: 0.
- zero and neg are evaluated for every operation.
- result_buffer:
  - On rising clk with result_en=1, loads alu_out; with result_en=0, holds its value.
  - reset low clears result_buffer to 0 immediately (asynchronously), regardless of clk.
  - Release of reset takes effect at the next edge.
- branch_address = pc + offset modulo 2^16; a negative offset branches backward. Unaffected by reset.
- Combinational outputs follow inputs during reset; only result_buffer is forced.

Optional Feature:
- Macro EXEC_SRA_EN.
- Defined: R-type func 101 decodes to alu_ctrl 101, an arithmetic right shift of a by b[3:0] that replicates the sign bit; overflow=0.
- Undefined: func 101 decodes to ADD, and alu_ctrl 101 never occurs.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams: OP_RTYPE, OP_JTYPE, OP_ANDI, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_FOR.
  - R-type func localparams.
  - typedef alu_op_t (3-bit enum) for the alu_ctrl encoding.
  - WIDTH default.
- One sub-module, exec_alu_decode: opcode/func → alu_op_t, pure combinational.
- ALU datapath, result register and branch adder live in exec_unit.

Test Plan:
- R-type ADD: opcode=0000, func=001, a=0x0005, b=0x0003 → alu_ctrl=001, alu_out=0x0008, zero=0, neg=0, overflow=0; after one clk, result_buffer=0x0008.
- BEQ with equal operands: opcode=0110, a=b=0x1234 → alu_ctrl=010, alu_out=0, zero=1. Separately, pc=0x0010, offset=0xFFFC → branch_address=0x000C.
- ADD overflow: func=001, a=0x7FFF, b=0x0001 → alu_out=0x8000, overflow=1, neg=1. SUB overflow: a=0x8000, b=0x0001 → alu_out=0x7FFF, overflow=1.
- Shifts: SLL a=0x0001, b=0x0004 → 0x0010. SRL a=0x8000, b=0x000F → 0x0001. With EXEC_SRA_EN, func=101, a=0x8000, b=0x0004 → 0xF800.
- Decode sweep: LW/SW/ADDI/0001 → 001; ANDI → 000; BNE/FOR → 010; R-type func 110/111 → 001.
- Reset and enable:
  - Load result_buffer=0x00FF, drive reset=0 mid-cycle → result_buffer=0 before the next edge.
  - With result_en=0, result_buffer holds across edges while alu_out changes.
